// File: rtl/core_mem_bridge_pkg.sv
// Shared types and constants for the core-to-RAM wait-state bridge.
// Holds the FSM state encoding, MMIO decode bit and wait-counter width.
package core_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;

    localparam int MMIO_SEL_BIT = 31;
    localparam int CNT_W        = 3;

endpackage

// File: rtl/core_mem_bridge_lat.sv
// Loadable down-counter timing RAM read latency; load wins over decrement.
// Counts down to zero and stops there; done flags the final wait cycle (value==1).
module core_mem_bridge_lat
    import core_mem_bridge_pkg::*;
(
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             done
);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == CNT_W'(1));

endmodule

// File: rtl/core_mem_bridge.sv
// Stalls the core (core_ce=0) around each access to a fixed-latency sync RAM; reads ack RAM_LAT+1 after sampling, writes/MMIO after 1.
// Optional GPIO register in the MMIO window (core_a[31]=1) when BRIDGE_GPIO_EN is defined; otherwise MMIO is acked but inert.
module core_mem_bridge
    import core_mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int RAM_LAT = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [31:0]       core_a,
    input  logic [31:0]       core_o,
    input  logic              core_w,
    output logic [31:0]       core_i,
    output logic              core_ce,
    output logic [ADDR_W-1:0] ram_a,
    output logic [31:0]       ram_d,
    output logic              ram_we,
    input  logic [31:0]       ram_q,
    output logic [31:0]       gpio_out,
    input  logic [31:0]       gpio_in
);

    state_t           state_q;
    state_t           state_d;
    logic             is_mmio;
    logic             cnt_load;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_val;
    logic             ram_we_d;
    logic             ram_rd_done;
    logic             mmio_rd;
    logic             mmio_wr;
    logic [31:0]      mmio_rdata;

    // Upper RAM-window bits alias and the byte offset is meaningless for word accesses.
    logic unused_addr;
    assign unused_addr = ^{core_a[30:ADDR_W+2], core_a[1:0]};

    assign is_mmio = core_a[MMIO_SEL_BIT];
    assign core_ce = (state_q == ACK);

    core_mem_bridge_lat u_lat (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_W'(RAM_LAT)),
        .value    (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_load    = 1'b0;
        ram_we_d    = 1'b0;
        ram_rd_done = 1'b0;
        mmio_rd     = 1'b0;
        mmio_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mmio) begin
                    mmio_wr = core_w;
                    mmio_rd = !core_w;
                    state_d = ACK;
                end else if (core_w) begin
                    ram_we_d = 1'b1;
                    state_d  = ACK;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_done) begin
                    ram_rd_done = 1'b1;
                    state_d     = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address/data only follow the core while idle, so churn during a wait is ignored.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
            core_i  <= '0;
            ram_we  <= 1'b0;
            ram_a   <= '0;
            ram_d   <= '0;
        end else begin
            state_q <= state_d;
            ram_we  <= ram_we_d;
            if (state_q == IDLE) begin
                ram_a <= core_a[ADDR_W+1:2];
                ram_d <= core_o;
            end
            if (ram_rd_done) begin
                core_i <= ram_q;
            end else if (mmio_rd) begin
                core_i <= mmio_rdata;
            end
        end
    end

`ifdef BRIDGE_GPIO_EN
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            gpio_out <= '0;
        end else if (mmio_wr) begin
            gpio_out <= core_o;
        end
    end

    assign mmio_rdata = gpio_in;
`else
    // Without the GPIO block MMIO still acks so a stray access cannot hang the core.
    logic unused_gpio;
    assign unused_gpio = ^{gpio_in, mmio_wr};
    assign gpio_out    = '0;
    assign mmio_rdata  = '0;
`endif

endmodule
